// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, operand/product types and issue FSM states for the multiplier issue stage
package mul_pkg;
    localparam int WIDTH     = 4;
    localparam int OUT_WIDTH = 2 * WIDTH;

    typedef logic [WIDTH-1:0]     operand_t;
    typedef logic [OUT_WIDTH-1:0] product_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
    } mul_req_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/mul_req_fifo.sv
// rtl/mul_req_fifo.sv - DEPTH-entry synchronous FIFO of operand pairs, wrap-bit pointers, async reset
module mul_req_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  mul_req_t push_data,
    input  logic     pop,
    output mul_req_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    mul_req_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head    = mem[rd_ptr[AW-1:0]];
    // A push while full is refused even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue stage: queues operand pairs, launches one at a time, captures products.
// Optional constant-time exit gated by MUL_ISSUE_CONST_TIME_EN.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LAT_MAX = WIDTH + 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     req_valid,
    output logic     req_ready,
    input  operand_t req_a,
    input  operand_t req_b,
    output logic     mul_in_valid,
    output operand_t mul_a,
    output operand_t mul_b,
    input  logic     mul_stall,
    input  logic     mul_out_valid,
    input  product_t mul_o,
    output logic     res_valid,
    output product_t res_o,
    output logic     idle,
    output logic     err_spurious
);
    if (LAT_MAX < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("mul_issue_ctrl: unsupported DEPTH/LAT_MAX");
    end

    state_t   state;
    state_t   state_nxt;
    mul_req_t head;
    logic     full;
    logic     empty;
    logic     capture;
    logic     finish;
    logic     exit_ok;

    mul_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data ('{a: req_a, b: req_b}),
        .pop       (mul_in_valid),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign req_ready = !full;
    assign mul_a     = empty ? '0 : head.a;
    assign mul_b     = empty ? '0 : head.b;
    assign idle      = empty && (state == IDLE);

`ifdef MUL_ISSUE_CONST_TIME_EN
    localparam int CW = $clog2(LAT_MAX + 1);
    logic [CW-1:0] cnt;
    logic          done;

    // A completion arriving in the final counted cycle still exits on time.
    assign exit_ok = (cnt == CW'(LAT_MAX)) && (done || mul_out_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (mul_in_valid) begin
            cnt  <= CW'(1);
            done <= 1'b0;
        end else if (state == WAIT && !mul_stall) begin
            if (cnt != CW'(LAT_MAX)) cnt <= cnt + CW'(1);
            if (mul_out_valid)       done <= 1'b1;
        end
    end
`else
    assign exit_ok = mul_out_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!mul_stall) begin
            case (state)
                IDLE:    if (!empty) state_nxt = WAIT;
                WAIT:    if (exit_ok) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mul_in_valid = (state == IDLE) && !empty && !mul_stall;
        capture      = (state == WAIT) && !mul_stall && mul_out_valid;
        finish       = (state == WAIT) && !mul_stall && exit_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_o        <= '0;
            err_spurious <= 1'b0;
        end else begin
            res_valid <= finish;
            if (capture) res_o <= mul_o;
            if (mul_out_valid && state != WAIT) err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - scoreboard bench for mul_issue_ctrl with a lock-stepped multiplier model
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    localparam int DEPTH   = 4;
    localparam int LAT_MAX = WIDTH + 2;
`ifdef MUL_ISSUE_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic     clk, rst, req_valid, req_ready, mul_in_valid, mul_stall, mul_out_valid;
    logic     res_valid, idle, err_spurious;
    operand_t req_a, req_b, mul_a, mul_b;
    product_t mul_o, res_o;

    mul_issue_ctrl #(.DEPTH(DEPTH), .LAT_MAX(LAT_MAX)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_in_valid(mul_in_valid),
        .mul_a(mul_a), .mul_b(mul_b), .mul_stall(mul_stall),
        .mul_out_valid(mul_out_valid), .mul_o(mul_o), .res_valid(res_valid),
        .res_o(res_o), .idle(idle), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {operand_t a; operand_t b;} pair_t;
    typedef struct {product_t p; int t0; int d;} res_t;

    pair_t    exp_q[$];
    res_t     res_q[$];
    int       dly_q[$];
    int       fifo_cnt = 0;
    int       nst = 0;
    bit       busy = 0, exp_err = 0;
    bit       m_active = 0;
    int       m_start = 0, m_delay = 0;
    product_t m_prod = '0;
    bit       stall_force = 0, stall_rand = 0, force_ov = 0;

    // Multiplier model: completes d non-stalled cycles after launch and holds while stalled.
    always @(posedge clk) begin
        #2;
        mul_stall     = stall_force || (stall_rand && $urandom_range(3) == 0);
        mul_out_valid = force_ov || (m_active && (nst - m_start) == m_delay);
        mul_o         = force_ov ? product_t'(8'hA5) : m_prod;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        pair_t p;
        res_t  r;
        bit    exp_launch;
        if (rst) begin
            exp_q.delete(); res_q.delete(); dly_q.delete();
            fifo_cnt = 0; busy = 0; exp_err = 0; m_active = 0;
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_o", res_o, 0);
            chk("rst_idle", idle, 1);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_mul_in_valid", mul_in_valid, 0);
            chk("rst_err", err_spurious, 0);
        end else begin
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    chk("res_unexpected", res_valid, 0);
                end else begin
                    r = res_q.pop_front();
                    chk("res_o", res_o, r.p);
                    chk("latency", nst - r.t0, CT ? LAT_MAX + 1 : r.d + 1);
                end
                busy = 0;
            end
            exp_launch = !busy && fifo_cnt > 0 && !mul_stall;
            chk("req_ready", req_ready, fifo_cnt < DEPTH);
            chk("idle", idle, fifo_cnt == 0 && !busy);
            chk("launch", mul_in_valid, exp_launch);
            chk("err_spurious", err_spurious, exp_err);
            if (exp_q.size() == 0) begin
                chk("head_a_empty", mul_a, 0);
                chk("head_b_empty", mul_b, 0);
            end else begin
                chk("head_a", mul_a, exp_q[0].a);
                chk("head_b", mul_b, exp_q[0].b);
            end
            if (mul_out_valid && !busy) exp_err = 1;
            if (mul_out_valid && !mul_stall && m_active) m_active = 0;
            if (mul_in_valid && exp_q.size() > 0) begin
                p      = exp_q.pop_front();
                r.p    = product_t'(p.a) * product_t'(p.b);
                r.t0   = nst;
                r.d    = (dly_q.size() > 0) ? dly_q.pop_front() : int'($urandom_range(LAT_MAX, 1));
                res_q.push_back(r);
                m_active = 1; m_start = nst; m_delay = r.d;
                m_prod   = product_t'(mul_a) * product_t'(mul_b);
                busy     = 1;
                fifo_cnt--;
            end
            if (req_valid && req_ready) begin
                p.a = req_a; p.b = req_b;
                exp_q.push_back(p);
                fifo_cnt++;
            end
            if (!mul_stall) nst++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push_pair(input operand_t a, input operand_t b);
        int k = 0;
        req_valid = 1; req_a = a; req_b = b;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready && k < 300);
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: req_ready stuck at 0, required 1");
        end
        step(1);
        req_valid = 0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || res_q.size() != 0 || busy || m_active) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d pending, required 0", exp_q.size() + res_q.size());
        end
        step(1);
    endtask

    task automatic pulse_reset();
        rst = 1; step(1); rst = 0; step(1);
    endtask

    initial begin
        int k;
        rst = 1; req_valid = 0; req_a = '0; req_b = '0;
        mul_stall = 0; mul_out_valid = 0; mul_o = '0;
        step(3);
        rst = 0;
        step(1);

        // Single transaction, completion 3 cycles after launch.
        dly_q.push_back(3);
        push_pair(4'd3, 4'd5);
        wait_drain();
        chk("t1_res_o", res_o, 15);
        chk("t1_idle", idle, 1);

        // Fill FIFO while stalled, then a fifth pair once a launch frees a slot.
        stall_force = 1;
        for (int i = 1; i <= 4; i++) push_pair(operand_t'(i), operand_t'(i + 10));
        step(1);
        chk("t2_full", req_ready, 0);
        stall_force = 0;
        push_pair(4'd5, 4'd15);
        wait_drain();

        // Stall in IDLE with a queued pair, then a stall across completion.
        stall_force = 1;
        push_pair(4'd7, 4'd9);
        step(3);
        stall_force = 0;
        dly_q.push_back(1);
        push_pair(4'd2, 4'd3);
        step(2);
        stall_force = 1;
        step(3);
        stall_force = 0;
        wait_drain();

        // Reset during WAIT with two entries queued, then a stray completion.
        stall_force = 1;
        for (int i = 0; i < 3; i++) begin
            dly_q.push_back(LAT_MAX);
            push_pair(operand_t'(i + 6), 4'd2);
        end
        stall_force = 0;
        k = 0;
        while (!busy && k < 50) begin @(negedge clk); k++; end
        step(1);
        rst = 1; step(1); rst = 0;
        step(1);
        chk("t4_idle", idle, 1);
        force_ov = 1; step(1); force_ov = 0;
        step(2);
        chk("t4_err", err_spurious, 1);
        step(3);
        chk("t6_err_sticky", err_spurious, 1);
        pulse_reset();

        // Data-independent timing pair: fast and slow completions.
        dly_q.push_back(2); dly_q.push_back(LAT_MAX);
        push_pair(4'd0, 4'd7);
        push_pair(4'd15, 4'd15);
        wait_drain();
        chk("t5_res_o", res_o, 225);

        // Randomized traffic with random stalls and latencies.
        stall_rand = 1;
        for (int i = 0; i < 120; i++) begin
            push_pair(operand_t'($urandom), operand_t'($urandom));
            if ($urandom_range(3) == 0) step($urandom_range(6, 1));
        end
        wait_drain();
        stall_rand = 0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
